// File: rtl/mdio_pkg.sv
// Shared definitions for the clause-22 MDIO PHY responder.
// Holds the frame FSM state encoding, opcode values, framing lengths and
// the indices of the fixed-function registers.
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RD_DATA,
    S_WR_DATA,
    S_SKIP
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Sized to match the 6-bit bit/preamble counter in the responder.
  localparam logic [5:0] PREAMBLE_LEN    = 6'd32;
  localparam logic [5:0] FRAME_TAIL_BITS = 6'd18;

  localparam logic [4:0] REG_CTRL = 5'd0;
  localparam logic [4:0] REG_STAT = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;

endpackage

// File: rtl/mdio_phy_regfile.sv
// 32 x 16-bit PHY register file.
//   clk, rst          : system clock, synchronous active-high reset
//   rd_addr / rd_data : combinational read port
//   wr_en / wr_addr / wr_data : single-cycle write port
// Registers 1..3 are read-only constants. Writing register 0 with bit 15
// set reloads every writable register to its reset value; bit 15 always
// reads back 0.
// Build option: MDIO_PREAMBLE_SUPPRESSION_EN sets status bit 6 on reads.
module mdio_phy_regfile
  import mdio_pkg::*;
#(
  parameter logic [15:0] CTRL_DEFAULT = 16'h3100,
  parameter logic [15:0] STATUS_VAL   = 16'h782D,
  parameter logic [15:0] ID1_VAL      = 16'h0007,
  parameter logic [15:0] ID2_VAL      = 16'hC0F1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data
);

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
  localparam logic [15:0] STATUS_RD = STATUS_VAL | 16'h0040;
`else
  localparam logic [15:0] STATUS_RD = STATUS_VAL;
`endif

  logic [15:0] mem_q [32];
  logic [15:0] mem_d [32];

  function automatic logic [15:0] reset_val(input int unsigned idx);
    return (idx == 0) ? CTRL_DEFAULT : '0;
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      if ((wr_addr == REG_CTRL) && wr_data[15]) begin
        for (int unsigned i = 0; i < 32; i++) begin
          mem_d[i[4:0]] = reset_val(i);
        end
      end else if (!(wr_addr inside {REG_STAT, REG_ID1, REG_ID2})) begin
        mem_d[wr_addr] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        mem_q[i[4:0]] <= reset_val(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    case (rd_addr)
      REG_CTRL: rd_data = {1'b0, mem_q[REG_CTRL][14:0]};
      REG_STAT: rd_data = STATUS_RD;
      REG_ID1:  rd_data = ID1_VAL;
      REG_ID2:  rd_data = ID2_VAL;
      default:  rd_data = mem_q[rd_addr];
    endcase
  end

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management responder (PHY side), fully in the clk domain.
//   clk, rst           : system clock (>= 8x MDC), synchronous active-high reset
//   mdc, mdio_i        : management clock and data pad input, both synchronised
//   mdio_o, mdio_oe    : pad output value and enable (inout built above)
//   wr_strobe/addr/data: one-clk notification of a committed register write
//   frame_err          : one-clk pulse on bad ST, bad OP or bad write TA
// Build option: MDIO_PREAMBLE_SUPPRESSION_EN lets frames after the first
// completed one start without a preamble.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] ID1_VAL      = 16'h0007,
  parameter logic [15:0] ID2_VAL      = 16'hC0F1,
  parameter logic [15:0] STATUS_VAL   = 16'h782D,
  parameter logic [15:0] CTRL_DEFAULT = 16'h3100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  logic mdc_s1_q, mdc_s2_q, mdc_d_q;
  logic mdio_s1_q, mdio_s2_q;
  logic mdc_rise, bit_in, st_ok;

  mdio_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_hi_q, op_hi_d;
  logic        is_read_q, is_read_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] shreg_q, shreg_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;

  logic        rf_wr_en;
  logic [4:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic [15:0] wr_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s1_q  <= 1'b0;
      mdc_s2_q  <= 1'b0;
      mdc_d_q   <= 1'b0;
      mdio_s1_q <= 1'b0;
      mdio_s2_q <= 1'b0;
    end else begin
      mdc_s1_q  <= mdc;
      mdc_s2_q  <= mdc_s1_q;
      mdc_d_q   <= mdc_s2_q;
      mdio_s1_q <= mdio_i;
      mdio_s2_q <= mdio_s1_q;
    end
  end

  assign mdc_rise = mdc_s2_q & ~mdc_d_q;
  assign bit_in   = mdio_s2_q;

  // The read snapshot is taken on the edge that samples REGAD[0], so the
  // address is formed from the bits already shifted plus the current bit.
  assign rf_rd_addr = {regad_q[3:0], bit_in};
  assign wr_word    = {shreg_q[14:0], bit_in};

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
  logic seen_q, seen_d;
  assign st_ok = (cnt_q == PREAMBLE_LEN) || seen_q;
  always_ff @(posedge clk) begin
    if (rst) seen_q <= 1'b0;
    else     seen_q <= seen_d;
  end
`else
  assign st_ok = (cnt_q == PREAMBLE_LEN);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shreg_d     = shreg_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    rf_wr_en    = 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
    seen_d      = seen_q;
`endif
    if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (bit_in) begin
            if (cnt_q != PREAMBLE_LEN) cnt_d = cnt_q + 6'd1;
          end else if (st_ok) begin
            state_d = S_ST;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
        S_ST: begin
          cnt_d = '0;
          if (bit_in) begin
            state_d = S_OP;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_OP: begin
          op_hi_d = bit_in;
          if (cnt_q == 6'd0) begin
            cnt_d = 6'd1;
          end else begin
            cnt_d = '0;
            if ({op_hi_q, bit_in} == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = S_PHYAD;
            end else if ({op_hi_q, bit_in} == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = S_PHYAD;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          phyad_d = {phyad_q[3:0], bit_in};
          if (cnt_q == 6'd4) begin
            cnt_d   = '0;
            state_d = S_REGAD;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_REGAD: begin
          regad_d = rf_rd_addr;
          if (cnt_q == 6'd4) begin
            cnt_d = '0;
            if (phyad_q != PHY_ADDR) begin
              state_d = S_SKIP;
            end else begin
              state_d = S_TA;
              if (is_read_q) shreg_d = rf_rd_data;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_TA: begin
          if (is_read_q) begin
            if (cnt_q == 6'd0) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
              cnt_d     = 6'd1;
            end else begin
              mdio_o_d = shreg_q[15];
              shreg_d  = {shreg_q[14:0], 1'b0};
              cnt_d    = '0;
              state_d  = S_RD_DATA;
            end
          end else if (cnt_q == 6'd0) begin
            if (bit_in) begin
              cnt_d = 6'd1;
            end else begin
              // SKIP's counter resumes at the number of tail bits consumed.
              frame_err_d = 1'b1;
              state_d     = S_SKIP;
              cnt_d       = 6'd1;
            end
          end else if (!bit_in) begin
            cnt_d   = '0;
            state_d = S_WR_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_SKIP;
            cnt_d       = 6'd2;
          end
        end
        S_RD_DATA: begin
          if (cnt_q == 6'd15) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
            cnt_d     = '0;
            state_d   = S_IDLE;
`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
            seen_d    = 1'b1;
`endif
          end else begin
            mdio_o_d = shreg_q[15];
            shreg_d  = {shreg_q[14:0], 1'b0};
            cnt_d    = cnt_q + 6'd1;
          end
        end
        S_WR_DATA: begin
          shreg_d = wr_word;
          if (cnt_q == 6'd15) begin
            rf_wr_en    = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = regad_q;
            wr_data_d   = wr_word;
            cnt_d       = '0;
            state_d     = S_IDLE;
`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
            seen_d      = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_SKIP: begin
          if (cnt_q == FRAME_TAIL_BITS - 6'd1) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_hi_q     <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      shreg_q     <= '0;
      mdio_o_q    <= 1'b0;
      mdio_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      shreg_q     <= shreg_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

  mdio_phy_regfile #(
    .CTRL_DEFAULT (CTRL_DEFAULT),
    .STATUS_VAL   (STATUS_VAL),
    .ID1_VAL      (ID1_VAL),
    .ID2_VAL      (ID2_VAL)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rf_rd_addr),
    .rd_data (rf_rd_data),
    .wr_en   (rf_wr_en),
    .wr_addr (regad_q),
    .wr_data (wr_word)
  );

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder acting as an MDIO master.
// Build option: MDIO_PREAMBLE_SUPPRESSION_EN changes the expected status
// bit 6 and whether a preamble-less frame is answered.
module tb_mdio_phy_responder;

`ifdef MDIO_PREAMBLE_SUPPRESSION_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;

  mdio_phy_responder dut (
    .clk       (clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Pulse monitors, sampled on the falling clk edge.
  int unsigned n_wr  = 0;
  int unsigned n_err = 0;
  int unsigned n_oe  = 0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      n_wr      <= n_wr + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (frame_err) n_err <= n_err + 1;
    if (mdio_oe)   n_oe  <= n_oe + 1;
  end

  // Behavioural register-file model.
  logic [15:0] ref_mem [32];

  function automatic void ref_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;
    ref_mem[0] = 16'h3100;
  endfunction

  function automatic void ref_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0 && d[15]) ref_reset();
    else if (a >= 5'd1 && a <= 5'd3) return;
    else ref_mem[a] = d;
  endfunction

  function automatic logic [15:0] ref_read(input logic [4:0] a);
    case (a)
      5'd0:    return ref_mem[0] & 16'h7FFF;
      5'd1:    return 16'h782D | (SUPPRESS ? 16'h0040 : 16'h0000);
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      default: return ref_mem[a];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic obs_oe [33];
  logic obs_o  [33];

  // One MDC period: drive the bit while MDC is low, observe the pad just
  // before the rising edge (i.e. the response to the previous edge).
  task automatic send_bit(input logic b, output logic oe_s, output logic o_s);
    mdio_i = b;
    mdc    = 1'b0;
    repeat (8) @(negedge clk);
    oe_s = mdio_oe;
    o_s  = mdio_o;
    mdc  = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input int unsigned pre, input logic [31:0] bits, input int rst_at);
    logic a, b;
    for (int i = 0; i < int'(pre); i++) send_bit(1'b1, a, b);
    for (int i = 0; i < 32; i++) begin
      if (i == rst_at) begin
        mdio_i = 1'b1;
        mdc    = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre_oe", 32'(mdio_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_oe_drop", 32'(mdio_oe), 32'd0);
        repeat (8) @(negedge clk);
        ref_reset();
        return;
      end
      send_bit(bits[31-i], a, b);
      obs_oe[i] = a;
      obs_o[i]  = b;
    end
    send_bit(1'b1, a, b);
    obs_oe[32] = a;
    obs_o[32]  = b;
  endtask

  task automatic read_reg(input string tag, input logic [4:0] phy, input logic [4:0] ra,
                          input int unsigned pre, input bit answer);
    logic [15:0] rd, oem;
    int unsigned oe0, err0;
    oe0  = n_oe;
    err0 = n_err;
    run_frame(pre, {2'b01, 2'b10, phy, ra, 2'b11, 16'hFFFF}, -1);
    for (int k = 0; k < 16; k++) begin
      rd[15-k]  = obs_o[16+k];
      oem[15-k] = obs_oe[16+k];
    end
    if (answer) begin
      check({tag, "_ta1_oe"}, 32'(obs_oe[14]), 32'd0);
      check({tag, "_ta2_drv"}, 32'({obs_oe[15], obs_o[15]}), 32'd2);
      check({tag, "_data_oe"}, 32'(oem), 32'hFFFF);
      check({tag, "_data"}, 32'(rd), 32'(ref_read(ra)));
      check({tag, "_release"}, 32'(obs_oe[32]), 32'd0);
    end else begin
      check({tag, "_no_oe"}, n_oe - oe0, 32'd0);
    end
    check({tag, "_no_err"}, n_err - err0, 32'd0);
  endtask

  task automatic write_reg(input string tag, input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] d, input logic [1:0] ta);
    int unsigned wr0, err0, oe0;
    bit commit, bad_ta;
    commit = (phy == 5'd1) && (ta == 2'b10);
    bad_ta = (phy == 5'd1) && (ta != 2'b10);
    wr0  = n_wr;
    err0 = n_err;
    oe0  = n_oe;
    run_frame(32, {2'b01, 2'b01, phy, ra, ta, d}, -1);
    check({tag, "_strobes"}, n_wr - wr0, commit ? 32'd1 : 32'd0);
    check({tag, "_errs"}, n_err - err0, bad_ta ? 32'd1 : 32'd0);
    check({tag, "_no_oe"}, n_oe - oe0, 32'd0);
    if (commit) begin
      check({tag, "_wr_addr"}, 32'(last_addr), 32'(ra));
      check({tag, "_wr_data"}, 32'(last_data), 32'(d));
      ref_write(ra, d);
    end
  endtask

  initial begin
    logic [4:0]  a;
    logic [15:0] d;
    int unsigned e0, o0;

    rst    = 1'b1;
    mdc    = 1'b0;
    mdio_i = 1'b1;
    ref_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({mdio_oe, mdio_o, wr_strobe, frame_err}), 32'd0);
    check("reset_wr_bus", 32'({wr_addr, wr_data}), 32'd0);

    // Short preamble right after reset: ignored in every build.
    read_reg("pre31", 5'd1, 5'd2, 31, 1'b0);

    read_reg("rd_id1", 5'd1, 5'd2, 32, 1'b1);
    read_reg("rd_ctrl_rst", 5'd1, 5'd0, 32, 1'b1);
    read_reg("rd_stat", 5'd1, 5'd1, 32, 1'b1);
    read_reg("rd_id2", 5'd1, 5'd3, 32, 1'b1);

    write_reg("wr_a5a5", 5'd1, 5'd4, 16'hA5A5, 2'b10);
    read_reg("rd_a5a5", 5'd1, 5'd4, 32, 1'b1);

    read_reg("rd_phy3", 5'd3, 5'd2, 32, 1'b0);
    write_reg("wr_phy3", 5'd3, 5'd4, 16'h5555, 2'b10);
    read_reg("rd_after_mis", 5'd1, 5'd2, 32, 1'b1);

    // OP=11, remaining bits idle-high so nothing restarts a frame.
    e0 = n_err;
    o0 = n_oe;
    run_frame(32, {2'b01, 2'b11, 5'h1F, 5'h1F, 2'b11, 16'hFFFF}, -1);
    check("op11_err", n_err - e0, 32'd1);
    check("op11_no_oe", n_oe - o0, 32'd0);
    read_reg("rd_after_op11", 5'd1, 5'd4, 32, 1'b1);

    write_reg("wr_ta00", 5'd1, 5'd4, 16'h1111, 2'b00);
    read_reg("rd_after_ta00", 5'd1, 5'd4, 32, 1'b1);

    write_reg("wr_ro", 5'd1, 5'd2, 16'hFFFF, 2'b10);
    read_reg("rd_ro", 5'd1, 5'd2, 32, 1'b1);

    write_reg("wr_1234", 5'd1, 5'd4, 16'h1234, 2'b10);
    write_reg("wr_soft", 5'd1, 5'd0, 16'h8000, 2'b10);
    read_reg("rd_soft_r4", 5'd1, 5'd4, 32, 1'b1);
    read_reg("rd_soft_r0", 5'd1, 5'd0, 32, 1'b1);

    for (int n = 0; n < 10; n++) begin
      a = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) write_reg("rnd_wr", 5'd1, a, d, 2'b10);
      read_reg("rnd_rd", 5'd1, a, 32, 1'b1);
    end

    write_reg("wr_r5", 5'd1, 5'd5, 16'($urandom | 32'h1), 2'b10);
    run_frame(32, {2'b01, 2'b10, 5'd1, 5'd5, 2'b11, 16'hFFFF}, 24);
    read_reg("rd_after_rst", 5'd1, 5'd5, 32, 1'b1);
    read_reg("rd_id_after_rst", 5'd1, 5'd2, 32, 1'b1);

    read_reg("no_preamble", 5'd1, 5'd2, 0, SUPPRESS);
    read_reg("rd_final", 5'd1, 5'd3, 32, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
